alu_mc: RTL

- Parametrised multi-cycle successor to the single-cycle 2-bit-select ALU in the datapath.
- Operations, single-cycle class: ADD, SUB, OR, AND, SLT.
- Operations, iterative class: unsigned MULTU (shift-add) and DIVU (restoring), with HI/LO results.
- Sits in the EX stage. Control issues an op with start and stalls the pipeline on busy until done.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_mc_iter.sv | 49 ++++
 rtl/alu_mc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_SLT   = 3'd4;
  localparam logic [2:0] OP_MULTU = 3'd5;
  localparam logic [2:0] OP_DIVU  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;
endpackage

// File: rtl/alu_mc_iter.sv
// Shared iterative datapath: shift-add multiply or restoring divide, one step per edge.
module alu_mc_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic [CNT_W-1:0]   cnt,
  output logic [2*WIDTH-1:0] acc_nxt
);
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    if (div_mode) begin
      if (div_trial[WIDTH])
        acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
      else
        acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      opb <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, in1};
      opb <= in2;
      cnt <= CNT_W'(WIDTH);
    end else if (step) begin
      acc <= acc_nxt;
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/OR/AND/SLT plus iterative MULTU/DIVU with HI/LO.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow_flag,
  output logic             less_than,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);
  state_t             state, state_nxt;
  logic               iter_load, iter_step, div_mode;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               upd, busy_nxt;
  logic [WIDTH-1:0]   n_out, n_hi;
  logic               n_ovf, n_lt, n_dbz;
  logic [WIDTH:0]     add_ext, sub_ext;
  logic               add_ovf, sub_ovf, sub_lt;

  alu_mc_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (iter_load),
    .step    (iter_step),
    .div_mode(div_mode),
    .in1     (in1),
    .in2     (in2),
    .cnt     (cnt),
    .acc_nxt (acc_nxt)
  );

  // overflow = carry into MSB xor carry out of MSB; signed compare corrects the sign by it
  always_comb begin
    add_ext = {1'b0, in1} + {1'b0, in2};
    sub_ext = {1'b0, in1} + {1'b0, ~in2} + (WIDTH+1)'(1);
    add_ovf = add_ext[WIDTH] ^ (in1[WIDTH-1] ^ in2[WIDTH-1] ^ add_ext[WIDTH-1]);
    sub_ovf = sub_ext[WIDTH] ^ (in1[WIDTH-1] ^ ~in2[WIDTH-1] ^ sub_ext[WIDTH-1]);
    sub_lt  = sub_ext[WIDTH-1] ^ sub_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    iter_load = 1'b0;
    iter_step = 1'b0;
    div_mode  = (state == ST_DIV);
    upd       = 1'b0;
    busy_nxt  = busy;
    n_out     = out;
    n_hi      = '0;
    n_ovf     = 1'b0;
    n_lt      = 1'b0;
    n_dbz     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          upd = 1'b1;
          case (sel)
            OP_ADD: begin
              n_out = add_ext[WIDTH-1:0];
              n_ovf = add_ovf;
            end
            OP_SUB: begin
              n_out = sub_ext[WIDTH-1:0];
              n_ovf = sub_ovf;
              n_lt  = sub_lt;
            end
            OP_AND: n_out = in1 & in2;
            OP_SLT: begin
              n_out = {{(WIDTH-1){1'b0}}, sub_lt};
              n_lt  = sub_lt;
            end
            OP_MULTU: begin
              upd       = 1'b0;
              iter_load = 1'b1;
              busy_nxt  = 1'b1;
              state_nxt = ST_MUL;
            end
            OP_DIVU: begin
              if (in2 == '0) begin
                n_out = '1;
                n_hi  = in1;
                n_dbz = 1'b1;
              end else begin
                upd       = 1'b0;
                iter_load = 1'b1;
                busy_nxt  = 1'b1;
                state_nxt = ST_DIV;
              end
            end
            default: n_out = in1 | in2;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        iter_step = 1'b1;
        if (cnt == CNT_W'(1)) begin
          upd         = 1'b1;
          {n_hi, n_out} = acc_nxt;
          busy_nxt    = 1'b0;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out           <= '0;
      hi            <= '0;
      zero          <= 1'b0;
      overflow_flag <= 1'b0;
      less_than     <= 1'b0;
      div_by_zero   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= upd;
      busy <= busy_nxt;
      if (upd) begin
        out           <= n_out;
        hi            <= n_hi;
        zero          <= (n_out == '0);
        overflow_flag <= n_ovf;
        less_than     <= n_lt;
        div_by_zero   <= n_dbz;
      end
    end
  end
endmodule
